// File: rtl/usb2_ep0in_tx.sv
// ---------------------------------------------------------------------------
// usb2_ep0in_tx
//   Streams one EP0 IN data packet from the 64x8 EP0 IN buffer RAM into the
//   USB2 packet-layer transmitter. The RAM has a 2-clock read latency, so a
//   small prefetch FIFO is kept topped up and bytes leave on a valid/ready
//   interface. A zero-length request produces a single ZLP marker beat.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, len          begin a packet of len bytes (clamped to MAX_PKT)
//   abort               cancel the current packet, no done pulse
//   busy, done          packet in progress / one-cycle completion pulse
//   rd_adr, rd_dat_r    RAM read address and data (data 2 clocks later)
//   tx_valid, tx_data,
//   tx_last, tx_zlp,
//   tx_ready            byte stream towards the packet layer
// ---------------------------------------------------------------------------
module usb2_ep0in_tx #(
    parameter int ADDR_W  = 6,
    parameter int MAX_PKT = 64,
    parameter int FIFO_D  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_adr,
    input  logic [7:0]        rd_dat_r,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_last,
    output logic              tx_zlp,
    input  logic              tx_ready
);

    localparam int PTR_W = $clog2(FIFO_D);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, ZLP, FIN} state_t;

    state_t            state, state_nxt;
    logic [6:0]        len_q;
    logic [6:0]        len_clamped;
    logic [6:0]        issued;
    logic [6:0]        sent;
    logic [1:0]        inflight_vld;
    logic [7:0]        fifo_mem [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] rd_adr_q;
    logic              issue;
    logic              push;
    logic              pop;
    logic              kill;

    // Request length clamp, and the FIFO slots already spoken for: entries
    // held plus reads still travelling through the RAM pipeline.
    always_comb begin
        len_clamped = (len > 7'(MAX_PKT)) ? 7'(MAX_PKT) : len;
        occupancy   = {1'b0, fifo_cnt} + (CNT_W+1)'(inflight_vld[0])
                                       + (CNT_W+1)'(inflight_vld[1]);
        kill        = abort && (state != IDLE);
        issue       = (state == STREAM) && !abort && (issued < len_q)
                      && (occupancy < (CNT_W+1)'(FIFO_D));
        push        = (state == STREAM) && inflight_vld[1];
        // The address goes out in the issue cycle itself so the RAM's two
        // clocks of latency line up with the second in-flight stage.
        rd_adr      = issue ? issued[ADDR_W-1:0] : rd_adr_q;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and packet-layer outputs. Abort overrides everything,
    // including a handshake in the same cycle, so pop is gated by it too.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'd0;
        tx_last   = 1'b0;
        tx_zlp    = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_clamped == 7'd0) ? ZLP : STREAM;
                end
            end
            STREAM: begin
                busy     = 1'b1;
                tx_valid = (fifo_cnt != '0);
                if (tx_valid) begin
                    tx_data = fifo_mem[rd_ptr];
                    // Bytes leave in order, so the head index is the sent count.
                    tx_last = (sent == len_q - 7'd1);
                end
                pop = tx_valid && tx_ready && !abort;
                if (pop && tx_last) begin
                    state_nxt = FIN;
                end
            end
            ZLP: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_zlp   = 1'b1;
                tx_last  = 1'b1;
                if (tx_ready) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (kill) begin
            state_nxt = IDLE;
        end
    end

    // Counters, read pipeline and FIFO pointers. An abort flushes the
    // in-flight flags so read data still returning from the RAM is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q        <= 7'd0;
            issued       <= 7'd0;
            sent         <= 7'd0;
            inflight_vld <= 2'b00;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            rd_adr_q     <= '0;
        end else begin
            rd_adr_q <= rd_adr;
            if ((state == IDLE) && start) begin
                len_q        <= len_clamped;
                issued       <= 7'd0;
                sent         <= 7'd0;
                inflight_vld <= 2'b00;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                fifo_cnt     <= '0;
            end else if (kill) begin
                inflight_vld <= 2'b00;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                fifo_cnt     <= '0;
            end else begin
                inflight_vld <= {inflight_vld[0], issue};
                if (issue) begin
                    issued <= issued + 7'd1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    sent   <= sent + 7'd1;
                end
                fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Prefetch FIFO storage; contents are meaningless once pointers reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rd_dat_r;
        end
    end

endmodule

// File: tb/tb_usb2_ep0in_tx.sv
// ---------------------------------------------------------------------------
// tb_usb2_ep0in_tx
//   Table-driven bench for usb2_ep0in_tx with a 2-clock-latency RAM model
//   preloaded with mem[i] = i, plus hand sequences for abort, start while
//   busy and asynchronous reset mid-packet.
// ---------------------------------------------------------------------------
module tb_usb2_ep0in_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] len;
    logic       abort;
    logic       busy;
    logic       done;
    logic [5:0] rd_adr;
    logic [7:0] rd_dat_r;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_zlp;
    logic       tx_ready;

    int vec_count  = 0;
    int miss_count = 0;
    int exp_rd_adr = 0;
    bit rd_known   = 1'b1;

    typedef struct {
        logic [6:0] len;
        bit         toggle;
        bit         fin_start;
        int         exp_beats;
        int         exp_first;
        int         exp_done;
    } vec_t;

    vec_t vecs [7];

    usb2_ep0in_tx dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rd_adr   (rd_adr),
        .rd_dat_r (rd_dat_r),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_zlp   (tx_zlp),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: address registered, then data registered -> 2-clock latency.
    logic [7:0] ram [64];
    logic [5:0] ram_adr_q;
    logic [7:0] ram_dat_q;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 8'(i);
    end

    always @(posedge clk) begin
        ram_adr_q <= rd_adr;
        ram_dat_q <= ram[ram_adr_q];
    end

    assign rd_dat_r = ram_dat_q;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Start one packet and follow it cycle by cycle up to its done pulse.
    // Cycle c=1 is the first cycle after the edge that samples start.
    task automatic applyStimulus(input vec_t v, input bit abort_at_start);
        int beats;
        start = 1'b1;
        len   = v.len;
        abort = abort_at_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        beats = 0;
        for (int c = 1; c <= v.exp_done; c++) begin
            tx_ready = v.toggle ? (c % 2 == 0) : 1'b1;
            if (c < v.exp_done) begin
                checkOutput("busy", 32'(busy), 32'd1);
                checkOutput("done_early", 32'(done), 32'd0);
                checkOutput("tx_valid", 32'(tx_valid), 32'(c >= v.exp_first));
                if (tx_valid) begin
                    checkOutput("tx_data", 32'(tx_data),
                                (v.len == 7'd0) ? 32'd0 : 32'(beats));
                    checkOutput("tx_last", 32'(tx_last),
                                32'((v.len == 7'd0) || (beats == v.exp_beats - 1)));
                    checkOutput("tx_zlp", 32'(tx_zlp), 32'(v.len == 7'd0));
                    if (tx_ready) beats++;
                end
            end else begin
                checkOutput("done", 32'(done), 32'd1);
                checkOutput("busy_at_done", 32'(busy), 32'd0);
                checkOutput("valid_at_done", 32'(tx_valid), 32'd0);
                checkOutput("beat_count", 32'(beats), 32'(v.exp_beats));
                if (v.len != 7'd0) begin
                    exp_rd_adr = v.exp_beats - 1;
                    rd_known   = 1'b1;
                end
                if (rd_known) checkOutput("rd_adr_hold", 32'(rd_adr), 32'(exp_rd_adr));
                if (v.fin_start) begin
                    start = 1'b1;
                    len   = 7'd3;
                end
            end
            @(negedge clk);
        end
        start    = 1'b0;
        tx_ready = 1'b1;
        checkOutput("done_once", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("idle_busy2", 32'(busy), 32'd0);
        checkOutput("idle_valid", 32'(tx_valid), 32'd0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_rd_adr"}, 32'(rd_adr), 32'd0);
        checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        checkOutput({tag, "_tx_last"}, 32'(tx_last), 32'd0);
        checkOutput({tag, "_tx_zlp"}, 32'(tx_zlp), 32'd0);
    endtask

    initial begin
        // len, toggle ready, start during FIN, beats, first valid c, done c
        vecs[0] = '{7'd5,   1'b0, 1'b0, 5,  4, 9};
        vecs[1] = '{7'd64,  1'b1, 1'b0, 64, 4, 131};
        vecs[2] = '{7'd0,   1'b0, 1'b0, 1,  1, 2};
        vecs[3] = '{7'd100, 1'b0, 1'b0, 64, 4, 68};
        vecs[4] = '{7'd1,   1'b0, 1'b0, 1,  4, 5};
        vecs[5] = '{7'd0,   1'b1, 1'b1, 1,  1, 3};
        vecs[6] = '{7'd65,  1'b0, 1'b0, 64, 4, 68};

        reset    = 1'b1;
        start    = 1'b0;
        len      = 7'd0;
        abort    = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkReset("rst");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], 1'b0);
        end

        // Abort after three of ten beats, with in-flight reads outstanding.
        start = 1'b1;
        len   = 7'd10;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c >= 4) begin
                checkOutput("abort_pre_valid", 32'(tx_valid), 32'd1);
                checkOutput("abort_pre_data", 32'(tx_data), 32'(c - 4));
            end
            if (c == 7) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checkOutput("abort_valid", 32'(tx_valid), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        rd_known = 1'b0;
        // abort in IDLE alongside start must not disturb the new packet
        applyStimulus('{7'd2, 1'b0, 1'b0, 2, 4, 6}, 1'b1);

        // Repeated start mid-packet, then asynchronous reset mid-packet.
        start = 1'b1;
        len   = 7'd10;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c >= 4) begin
                checkOutput("restart_data", 32'(tx_data), 32'(c - 4));
                checkOutput("restart_last", 32'(tx_last), 32'd0);
            end
            start = (c == 5);
            len   = (c == 5) ? 7'd3 : 7'd10;
            if (c < 8) @(negedge clk);
        end
        start = 1'b0;
        #2 reset = 1'b1;
        #1 checkReset("async");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("post_rst_done", 32'(done), 32'd0);
            checkOutput("post_rst_busy", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
